// File: rtl/jtframe_rom_arb.sv
// ROM read arbiter: several read slots, each with a one-line 32-bit cache,
// share a single SDRAM read port. Misses are fetched one at a time through a
// req/ack/data_rdy handshake; hits are served combinationally from the cache.
module jtframe_rom_arb #(
    parameter int unsigned         SLOTS   = 4,
    parameter int unsigned         SAW     = 18,
    parameter logic [SLOTS*22-1:0] OFFSETS = '0,
    parameter logic [SLOTS-1:0]    DW16    = '0,
    parameter int unsigned         RR      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SLOTS-1:0]       slot_cs,
    input  logic [SLOTS*SAW-1:0]   slot_addr,
    output logic [SLOTS-1:0]       slot_ok,
    output logic [SLOTS*16-1:0]    slot_dout,
    output logic                   sdram_req,
    input  logic                   sdram_ack,
    input  logic                   data_rdy,
    output logic [21:0]            sdram_addr,
    input  logic [31:0]            data_read,
    input  logic                   downloading,
    output logic                   refresh_en
);

    localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t           state_q;
    logic [IW-1:0]    gnt_q;
    logic [IW-1:0]    last_q;
    logic [SAW-1:0]   tag_lat_q;
    logic [31:0]      data_q  [SLOTS];
    logic [SAW-1:0]   tag_q   [SLOTS];
    logic [SLOTS-1:0] valid_q;

    logic [SAW-1:0]   addr_w   [SLOTS];
    logic [SAW-1:0]   line_idx [SLOTS];
    logic [21:0]      fetch    [SLOTS];
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pending;
    logic             gnt_any;
    logic [IW-1:0]    gnt_idx;
    int               cand;

    // Per-slot address decode, cache lookup and output data selection
    always_comb begin
        slot_ok   = '0;
        slot_dout = '0;
        hit       = '0;
        pending   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            addr_w[i]   = slot_addr[i*SAW +: SAW];
            // 16-bit slots address words, so a 32-bit line holds two of them
            line_idx[i] = DW16[i] ? (addr_w[i] >> 1) : (addr_w[i] >> 2);
            fetch[i]    = OFFSETS[i*22 +: 22] + (22'(line_idx[i]) << 1);
            hit[i]      = valid_q[i] && (tag_q[i] == line_idx[i]);
            pending[i]  = slot_cs[i] && !hit[i];
            slot_ok[i]  = slot_cs[i] && hit[i];
            if (DW16[i]) begin
                slot_dout[i*16 +: 16] = addr_w[i][0] ? data_q[i][31:16] : data_q[i][15:0];
            end else begin
                unique case (addr_w[i][1:0])
                    2'd0:    slot_dout[i*16 +: 16] = {8'd0, data_q[i][7:0]};
                    2'd1:    slot_dout[i*16 +: 16] = {8'd0, data_q[i][15:8]};
                    2'd2:    slot_dout[i*16 +: 16] = {8'd0, data_q[i][23:16]};
                    default: slot_dout[i*16 +: 16] = {8'd0, data_q[i][31:24]};
                endcase
            end
        end
    end

    // Pick the slot to serve next: lowest index, or first one after the last grant
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (RR != 0) begin
                cand = (int'(last_q) + 1 + k) % int'(SLOTS);
            end else begin
                cand = k;
            end
            if (!gnt_any && pending[IW'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

    // Refresh may run only while the port is idle and nobody is waiting on it
    always_comb begin
        refresh_en = (state_q == StIdle) && (pending == '0);
    end

    // Fetch sequencer and cache fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt_q      <= '0;
            last_q     <= IW'(SLOTS - 1);
            tag_lat_q  <= '0;
            valid_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (downloading) begin
            // ROM contents are being rewritten: drop everything, fill nothing
            state_q   <= StIdle;
            sdram_req <= 1'b0;
            valid_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        gnt_q      <= gnt_idx;
                        last_q     <= gnt_idx;
                        tag_lat_q  <= line_idx[gnt_idx];
                        sdram_addr <= fetch[gnt_idx];
                        sdram_req  <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    // Tag comes from the grant, not the live address, which may have moved
                    if (data_rdy) begin
                        data_q[gnt_q]  <= data_read;
                        tag_q[gnt_q]   <= tag_lat_q;
                        valid_q[gnt_q] <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: directed scenarios, a round-robin instance, and a
// randomized phase checked by a scoreboard against a behavioural memory model.
module tb_jtframe_rom_arb;

    localparam int unsigned         SLOTS = 4;
    localparam int unsigned         SAW   = 18;
    localparam logic [SLOTS*22-1:0] OFFS  = {22'h20000, 22'h0, 22'h1000, 22'h0};
    localparam logic [SLOTS-1:0]    DW    = 4'b0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Fixed-priority instance
    logic [SLOTS-1:0]     cs = '0;
    logic [SLOTS*SAW-1:0] addr = '0;
    logic [SLOTS-1:0]     ok;
    logic [SLOTS*16-1:0]  dout;
    logic                 req;
    logic                 ack = 1'b0;
    logic                 rdy = 1'b0;
    logic [21:0]          sa;
    logic [31:0]          dr = '0;
    logic                 dl = 1'b0;
    logic                 rf;

    // Round-robin instance
    logic [SLOTS-1:0]     rcs = '0;
    logic [SLOTS*SAW-1:0] raddr = '0;
    logic [SLOTS-1:0]     rok;
    logic [SLOTS*16-1:0]  rdout;
    logic                 rreq;
    logic                 rack = 1'b0;
    logic                 rrdy = 1'b0;
    logic [21:0]          rsa;
    logic [31:0]          rdr = '0;
    logic                 rdl = 1'b0;
    logic                 rrf;

    jtframe_rom_arb #(.SLOTS(SLOTS), .SAW(SAW), .OFFSETS(OFFS), .DW16(DW), .RR(0)) dut (
        .clk(clk), .rst_n(rst_n), .slot_cs(cs), .slot_addr(addr), .slot_ok(ok),
        .slot_dout(dout), .sdram_req(req), .sdram_ack(ack), .data_rdy(rdy),
        .sdram_addr(sa), .data_read(dr), .downloading(dl), .refresh_en(rf)
    );

    jtframe_rom_arb #(.SLOTS(SLOTS), .SAW(SAW), .OFFSETS('0), .DW16('0), .RR(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .slot_cs(rcs), .slot_addr(raddr), .slot_ok(rok),
        .slot_dout(rdout), .sdram_req(rreq), .sdram_ack(rack), .data_rdy(rrdy),
        .sdram_addr(rsa), .data_read(rdr), .downloading(rdl), .refresh_en(rrf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit             mon_en  = 1'b0;
    bit             resp_en = 1'b0;
    bit             mvalid [SLOTS];
    logic [SAW-1:0] mline  [SLOTS];
    int             gslot  = 0;
    logic [SAW-1:0] gline  = '0;
    logic [15:0]    exp_q  [SLOTS][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // SDRAM contents as a fixed hash of the word address
    function automatic logic [31:0] mem(input logic [21:0] w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [SAW-1:0] line_of(input int s, input logic [SAW-1:0] a);
        return DW[s] ? (a >> 1) : (a >> 2);
    endfunction

    function automatic logic [21:0] fetch_of(input int s, input logic [SAW-1:0] a);
        return OFFS[s*22 +: 22] + (22'(line_of(s, a)) << 1);
    endfunction

    function automatic logic [15:0] ref_dout(input int s, input logic [SAW-1:0] a);
        logic [31:0] d;
        d = mem(fetch_of(s, a));
        if (DW[s]) return a[0] ? d[31:16] : d[15:0];
        return {8'h00, d[8*a[1:0] +: 8]};
    endfunction

    function automatic logic [SAW-1:0] get_addr(input int s);
        return addr[s*SAW +: SAW];
    endfunction

    function automatic logic [15:0] get_dout(input int s);
        return dout[s*16 +: 16];
    endfunction

    task automatic set_addr(input int s, input logic [SAW-1:0] v);
        addr[s*SAW +: SAW] = v;
    endtask

    function automatic int queued();
        int n = 0;
        for (int s = 0; s < SLOTS; s++) n += exp_q[s].size();
        return n;
    endfunction

    // Directed ack + data delivery on the fixed-priority instance
    task automatic serve(input logic [31:0] d);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        rdy = 1'b1;
        dr  = d;
        tick();
        rdy = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: pops expected data when a slot presents ok, checks
    // ok against the model cache, and checks each new grant against the model
    initial begin : monitor
        int             snap_slot;
        logic [21:0]    snap_addr;
        logic [SAW-1:0] snap_line;
        logic           req_prev;
        logic [SAW-1:0] a;
        snap_slot = -1;
        snap_addr = '0;
        snap_line = '0;
        req_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int s = 0; s < SLOTS; s++) begin
                    a = get_addr(s);
                    if (cs[s] && ok[s] && exp_q[s].size() > 0)
                        check($sformatf("sb_dout%0d", s), 32'(get_dout(s)), 32'(exp_q[s].pop_front()));
                    check($sformatf("ok_model%0d", s), 32'(ok[s]),
                          32'(cs[s] && mvalid[s] && mline[s] == line_of(s, a)));
                end
                if (req && !req_prev) begin
                    check("grant_had_pending", 32'(snap_slot >= 0), 32'd1);
                    if (snap_slot >= 0) begin
                        check("grant_addr", 32'(sa), 32'(snap_addr));
                        gslot = snap_slot;
                        gline = snap_line;
                    end
                end
                snap_slot = -1;
                for (int s = 0; s < SLOTS; s++) begin
                    a = get_addr(s);
                    if (snap_slot < 0 && cs[s] && !(mvalid[s] && mline[s] == line_of(s, a))) begin
                        snap_slot = s;
                        snap_addr = fetch_of(s, a);
                        snap_line = line_of(s, a);
                    end
                end
            end
            req_prev = req;
        end
    end

    // SDRAM responder for the randomized phase, with random latencies
    initial begin : responder
        logic [21:0] a;
        forever begin
            @(posedge clk);
            #2;
            if (resp_en && req) begin
                a = sa;
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    check("req_hold", 32'({req, sa}), 32'({1'b1, a}));
                end
                ack = 1'b1;
                tick();
                ack = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
                dr  = mem(a);
                rdy = 1'b1;
                @(posedge clk);
                #1;
                mvalid[gslot] = 1'b1;
                mline[gslot]  = gline;
                #1;
                rdy = 1'b0;
                dr  = $urandom;
            end else if (resp_en && ($urandom_range(0, 7) == 0)) begin
                // stray data_rdy while idle must not fill anything
                dr  = $urandom;
                rdy = 1'b1;
                tick();
                rdy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cnt;
        int s;
        int gen [SLOTS];
        logic [3:0] mask;
        logic [SAW-1:0] a;

        for (int i = 0; i < SLOTS; i++) begin
            mvalid[i] = 1'b0;
            mline[i]  = '0;
            gen[i]    = 0;
        end

        // Reset values
        #3;
        check("rst_req", 32'(req), 32'd0);
        check("rst_addr", 32'(sa), 32'd0);
        check("rst_ok", 32'(ok), 32'd0);
        check("rst_dout", dout[31:0], 32'd0);
        check("rst_dout_hi", dout[63:32], 32'd0);
        check("rst_refresh", 32'(rf), 32'd1);
        tick();
        rst_n = 1'b1;

        // Miss then hit on 8-bit slot 1
        cs[1] = 1'b1;
        set_addr(1, 18'h6);
        #1;
        check("t1_miss_ok", 32'(ok[1]), 32'd0);
        check("t1_refresh_busy", 32'(rf), 32'd0);
        tick(); #1;
        check("t1_req", 32'(req), 32'd1);
        check("t1_addr", 32'(sa), 32'h1002);
        tick(); #1;
        check("t1_req_hold", 32'({req, sa}), 32'({1'b1, 22'h1002}));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        #1;
        check("t1_req_drop", 32'(req), 32'd0);
        rdy = 1'b1;
        dr  = 32'hDDCCBBAA;
        #1;
        check("t1_ok_before_fill", 32'(ok[1]), 32'd0);
        tick();
        rdy = 1'b0;
        #1;
        check("t1_ok", 32'(ok[1]), 32'd1);
        check("t1_dout", 32'(get_dout(1)), 32'h00CC);
        set_addr(1, 18'h7);
        #1;
        check("t1_hit_ok", 32'(ok[1]), 32'd1);
        check("t1_hit_dout", 32'(get_dout(1)), 32'h00DD);
        tick(); #1;
        check("t1_no_new_req", 32'(req), 32'd0);
        cs = '0;

        // 16-bit slot 2
        cs[2] = 1'b1;
        set_addr(2, 18'h3);
        tick(); #1;
        check("t2_addr", 32'({req, sa}), 32'({1'b1, 22'h2}));
        serve(32'h56781234);
        check("t2_ok", 32'(ok[2]), 32'd1);
        check("t2_dout_hi", 32'(get_dout(2)), 32'h5678);
        set_addr(2, 18'h2);
        #1;
        check("t2_dout_lo", 32'(get_dout(2)), 32'h1234);
        cs = '0;

        // Fixed priority: slots 0 and 3 miss together
        cs[0] = 1'b1;
        set_addr(0, 18'h100);
        cs[3] = 1'b1;
        set_addr(3, 18'h8);
        tick(); #1;
        check("t3_first", 32'({req, sa}), 32'({1'b1, 22'h80}));
        serve(32'h11111111);
        check("t3_idle_gap", 32'(req), 32'd0);
        tick(); #1;
        check("t3_second", 32'({req, sa}), 32'({1'b1, 22'h20004}));
        serve(32'h22222222);
        check("t3_ok", 32'(ok), 32'b1001);
        cs = '0;

        // Address change while a fetch is in flight
        cs[0] = 1'b1;
        set_addr(0, 18'h10);
        tick(); #1;
        check("t4_addr", 32'(sa), 32'h8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        set_addr(0, 18'h40);
        rdy = 1'b1;
        dr  = 32'hCAFEF00D;
        tick();
        rdy = 1'b0;
        #1;
        check("t4_ok_stale", 32'(ok[0]), 32'd0);
        check("t4_idle", 32'(req), 32'd0);
        tick(); #1;
        check("t4_rereq", 32'({req, sa}), 32'({1'b1, 22'h20}));
        set_addr(0, 18'h10);
        #1;
        check("t4_old_hit", 32'(ok[0]), 32'd1);
        check("t4_old_dout", 32'(get_dout(0)), 32'h000D);

        // Download abort during WAIT
        ack = 1'b1;
        tick();
        ack = 1'b0;
        dl = 1'b1;
        tick(); #1;
        check("t5_req", 32'(req), 32'd0);
        check("t5_ok", 32'(ok), 32'd0);
        cs = '0;
        #1;
        check("t5_refresh", 32'(rf), 32'd1);
        rdy = 1'b1;
        dr  = 32'h0BADBEEF;
        tick();
        rdy = 1'b0;
        dl  = 1'b0;
        cs[0] = 1'b1;
        set_addr(0, 18'h40);
        #1;
        check("t5_no_fill", 32'(ok[0]), 32'd0);
        tick(); #1;
        check("t5_new_req", 32'({req, sa}), 32'({1'b1, 22'h20}));

        // Asynchronous reset in REQ, away from any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(req), 32'd0);
        check("t6_addr", 32'(sa), 32'd0);
        check("t6_ok", 32'(ok), 32'd0);
        check("t6_dout", dout[31:0], 32'd0);
        check("t6_dout_hi", dout[63:32], 32'd0);
        cs = '0;
        #1;
        check("t6_refresh", 32'(rf), 32'd1);
        rst_n = 1'b1;
        tick(); #1;
        check("t6_stay_idle", 32'(req), 32'd0);

        // Round-robin: all four slots keep missing, grants go 0,1,2,3,0
        for (int i = 0; i < SLOTS; i++) raddr[i*SAW +: SAW] = SAW'(i << 8);
        rcs = '1;
        for (int n = 0; n < 5; n++) begin
            cnt = 0;
            while (!rreq && cnt < 20) begin
                tick();
                cnt++;
            end
            check("rr_req_seen", 32'(rreq), 32'd1);
            s = int'((rsa >> 7) & 22'h3);
            check($sformatf("rr_grant%0d", n), 32'(s), 32'(n % 4));
            gen[s]++;
            raddr[s*SAW +: SAW] = SAW'((s << 8) | (gen[s] << 2));
            rack = 1'b1;
            tick();
            rack = 1'b0;
            rrdy = 1'b1;
            rdr  = $urandom;
            tick();
            rrdy = 1'b0;
        end
        rcs = '0;

        // Randomized traffic against the scoreboard
        mon_en  = 1'b1;
        resp_en = 1'b1;
        tick();
        for (int r = 0; r < 150; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < SLOTS; i++) begin
                if (mask[i]) begin
                    a = SAW'($urandom_range(0, 23));
                    set_addr(i, a);
                    cs[i] = 1'b1;
                    exp_q[i].push_back(ref_dout(i, a));
                end
            end
            cnt = 0;
            while (queued() > 0 && cnt < 300) begin
                tick();
                cnt++;
            end
            if (queued() > 0) begin
                check("sb_timeout", 32'(queued()), 32'd0);
                for (int i = 0; i < SLOTS; i++) exp_q[i].delete();
            end
            cs = '0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (12) tick();
        mon_en  = 1'b0;
        resp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
